// File: rtl/umi_stream_writer.sv
// USI stream to UMI write initiator: each accepted beat becomes one write request
// whose destination walks a ring buffer; acknowledged mode tracks outstanding writes.
module umi_stream_writer #(
    parameter int AW     = 64,
    parameter int CW     = 32,
    parameter int DW     = 256,
    parameter int MAXOUT = 8,
    parameter int CNTW   = 16
) (
    input  logic            umi_clk,
    input  logic            umi_reset,
    input  logic            cfg_go,
    input  logic            cfg_posted,
    input  logic [AW-1:0]   cfg_base,
    input  logic [CNTW-1:0] cfg_ringbeats,
    input  logic [AW-1:0]   cfg_srcaddr,
    input  logic [4:0]      cfg_hostid,
    input  logic            usi_in_valid,
    input  logic            usi_in_last,
    input  logic [DW-1:0]   usi_in_data,
    output logic            usi_in_ready,
    output logic            umi_out_valid,
    output logic [CW-1:0]   umi_out_cmd,
    output logic [AW-1:0]   umi_out_dstaddr,
    output logic [AW-1:0]   umi_out_srcaddr,
    output logic [DW-1:0]   umi_out_data,
    input  logic            umi_out_ready,
    input  logic            umi_resp_valid,
    input  logic [CW-1:0]   umi_resp_cmd,
    output logic            umi_resp_ready,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [CNTW-1:0] frames
);
    localparam int SZ = $clog2(DW/8);
    localparam int OW = $clog2(MAXOUT) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_posted;
    logic [AW-1:0]   r_base;
    logic [CNTW-1:0] r_ring;
    logic [CNTW-1:0] r_idx;
    logic            r_out_valid;
    logic [CW-1:0]   r_out_cmd;
    logic [AW-1:0]   r_out_dst;
    logic [AW-1:0]   r_out_src;
    logic [DW-1:0]   r_out_data;
    logic [OW-1:0]   r_outst;
    logic            r_err;
    logic            r_done;
    logic [CNTW-1:0] r_frames;

    logic            w_go, w_accept, w_issue, w_inc, w_dec, w_resp_err, w_done_nxt;
    logic [4:0]      w_resp_op;
    logic [OW-1:0]   w_outst_nxt;
    logic [CNTW-1:0] w_idx_inc, w_idx_wrap;
    logic [AW-1:0]   w_addr;
    logic [CW-1:0]   w_cmd;
    logic            w_unused;

    assign w_unused   = ^umi_resp_cmd[CW-1:5];
    assign w_go       = cfg_go & (r_state == S_IDLE);
    assign w_accept   = usi_in_valid & usi_in_ready;
    assign w_issue    = r_out_valid & umi_out_ready;
    assign w_resp_op  = umi_resp_cmd[4:0];
    assign w_inc      = w_issue & !r_posted;
    assign w_dec      = umi_resp_valid & !r_posted & (w_resp_op == 5'h4) & (r_outst != '0);
    assign w_resp_err = umi_resp_valid & (r_posted | (w_resp_op != 5'h4) | (r_outst == '0));

    always_comb begin
        w_outst_nxt = r_outst;
        case ({w_inc, w_dec})
            2'b10:   w_outst_nxt = r_outst + OW'(1);
            2'b01:   w_outst_nxt = r_outst - OW'(1);
            default: w_outst_nxt = r_outst;
        endcase
    end

    // Gate on the post-update count so a same-cycle response frees a slot, and the
    // beat sitting in the output register can never push the count past MAXOUT.
    assign usi_in_ready = (r_state == S_RUN) & (!r_out_valid | umi_out_ready) &
                          (r_posted | (w_outst_nxt < OW'(MAXOUT)));

    assign w_idx_inc  = r_idx + CNTW'(1);
    assign w_idx_wrap = (w_idx_inc == r_ring) ? '0 : w_idx_inc;
    assign w_addr     = r_base + (AW'(r_idx) << SZ);

    always_comb begin
        w_cmd        = '0;
        w_cmd[4:0]   = r_posted ? 5'h5 : 5'h3;
        w_cmd[7:5]   = 3'(SZ);
        w_cmd[22]    = usi_in_last;
        w_cmd[23]    = usi_in_last;
        w_cmd[31:27] = cfg_hostid;
    end

    always_ff @(posedge umi_clk) begin
        if (umi_reset) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE:  if (cfg_go) w_state_nxt = S_RUN;
            S_RUN:   if (w_accept && usi_in_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (!r_out_valid && r_outst == '0) begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge umi_clk) begin
        if (umi_reset) begin
            r_posted    <= 1'b0;
            r_base      <= '0;
            r_ring      <= CNTW'(1);
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_cmd   <= '0;
            r_out_dst   <= '0;
            r_out_src   <= '0;
            r_out_data  <= '0;
            r_outst     <= '0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_frames    <= '0;
        end else begin
            r_done  <= w_done_nxt;
            r_outst <= w_outst_nxt;
            if (w_done_nxt) r_frames <= r_frames + CNTW'(1);
            if (w_go) begin
                r_posted <= cfg_posted;
                r_base   <= cfg_base;
                r_ring   <= (cfg_ringbeats == '0) ? CNTW'(1) : cfg_ringbeats;
                r_idx    <= '0;
            end else if (w_accept) begin
                r_idx    <= w_idx_wrap;
            end
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_cmd   <= w_cmd;
                r_out_dst   <= w_addr;
                r_out_src   <= cfg_srcaddr;
                r_out_data  <= usi_in_data;
            end else if (w_issue) begin
                r_out_valid <= 1'b0;
            end
            if (w_resp_err) r_err <= 1'b1;
            else if (w_go)  r_err <= 1'b0;
        end
    end

    assign umi_out_valid   = r_out_valid;
    assign umi_out_cmd     = r_out_cmd;
    assign umi_out_dstaddr = r_out_dst;
    assign umi_out_srcaddr = r_out_src;
    assign umi_out_data    = r_out_data;
    assign umi_resp_ready  = 1'b1;
    assign busy            = (r_state != S_IDLE);
    assign done            = r_done;
    assign err             = r_err;
    assign frames          = r_frames;
endmodule
